// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: opcode and state encodings shared by the accumulator sequencer
package accum_seq_pkg;
  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASHL = 4'd11,
    OP_ASHR = 4'd12
  } op_e;
  typedef enum logic [1:0] {IDLE, DIV, DONE_DIV} state_e;
  localparam int RESET_VAL_DEF = 10;
endpackage

// File: rtl/accum_op_sequencer_if.sv
// accum_op_sequencer_if: command handshake and status bundle of the accumulator sequencer
interface accum_op_sequencer_if import accum_seq_pkg::*; #(
  parameter int WIDTH = 32
);
  logic cmd_valid;
  logic cmd_ready;
  op_e cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [WIDTH-1:0] acc;
  logic done;
  logic busy;
  logic err_div0;
  logic err_clr;
  modport master (
    output cmd_valid, cmd_op, cmd_operand, err_clr,
    input cmd_ready, acc, done, busy, err_div0
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_operand, err_clr,
    output cmd_ready, acc, done, busy, err_div0
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring radix-2 unsigned divider, first step taken on the start edge
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [WIDTH-1:0] dividend,
  input logic [WIDTH-1:0] divisor,
  output logic busy,
  output logic valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvs, src_rem, src_quo, src_dvs;
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    src_rem = start ? '0 : remainder;
    src_quo = start ? dividend : quotient;
    src_dvs = start ? divisor : dvs;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff = shifted - {1'b0, src_dvs};
  end
  assign busy = cnt != '0 || valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      dvs <= '0;
    end else begin
      valid <= cnt == CW'(1);
      if (start || cnt != '0) begin
        remainder <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quotient <= {src_quo[WIDTH-2:0], !diff[WIDTH]};
        dvs <= src_dvs;
        cnt <= start ? CW'(WIDTH - 1) : cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/accum_op_sequencer.sv
// accum_op_sequencer: command-driven accumulator with single-cycle ALU and iterative divide/modulo
module accum_op_sequencer import accum_seq_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int RESET_VAL = RESET_VAL_DEF
) (
  input logic clk,
  input logic rst,
  accum_op_sequencer_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  state_e state;
  logic [WIDTH-1:0] acc, alu, quo, rem;
  logic [SW-1:0] sh;
  logic done, err, is_mod, accept, div_op, div_zero, start, div_busy, div_valid;
  assign sh = bus.cmd_operand[SW-1:0];
  assign accept = bus.cmd_valid && state == IDLE;
  assign div_op = bus.cmd_op == OP_DIV || bus.cmd_op == OP_MOD;
  assign div_zero = div_op && bus.cmd_operand == '0;
  assign start = accept && div_op && !div_zero;
  assign bus.cmd_ready = state == IDLE;
  assign bus.acc = acc;
  assign bus.done = done;
  assign bus.busy = div_busy || state == DONE_DIV;
  assign bus.err_div0 = err;
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(acc),
    .divisor(bus.cmd_operand),
    .busy(div_busy),
    .valid(div_valid),
    .quotient(quo),
    .remainder(rem)
  );
  always_comb begin
    alu = acc;
    case (bus.cmd_op)
      OP_LOAD: alu = bus.cmd_operand;
      OP_ADD: alu = acc + bus.cmd_operand;
      OP_SUB: alu = acc - bus.cmd_operand;
      OP_MUL: alu = acc * bus.cmd_operand;
      OP_AND: alu = acc & bus.cmd_operand;
      OP_OR: alu = acc | bus.cmd_operand;
      OP_XOR: alu = acc ^ bus.cmd_operand;
      OP_SHL, OP_ASHL: alu = acc << sh;
      OP_SHR: alu = acc >> sh;
      OP_ASHR: alu = WIDTH'($signed(acc) >>> sh);
      default: alu = acc;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= WIDTH'(RESET_VAL);
      done <= 1'b0;
      err <= 1'b0;
      is_mod <= 1'b0;
    end else begin
      state <= start ? DIV : (state == DIV && div_valid) ? DONE_DIV : state == DONE_DIV ? IDLE : state;
      done <= (accept && !start) || state == DONE_DIV;
      acc <= (accept && !start) ? alu : state == DONE_DIV ? (is_mod ? rem : quo) : acc;
      err <= (accept && div_zero) || (err && !bus.err_clr);
      is_mod <= start ? bus.cmd_op == OP_MOD : is_mod;
    end
  end
endmodule

// File: tb/tb_accum_op_sequencer.sv
// tb_accum_op_sequencer: directed and randomized checks of the sequencer against a reference model
module tb_accum_op_sequencer;
  import accum_seq_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_acc;
  logic m_err;
  always #5 clk = ~clk;
  accum_op_sequencer_if #(.WIDTH(W)) bus();
  accum_op_sequencer #(.WIDTH(W), .RESET_VAL(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    logic [W-1:0] ones;
    sh = int'(b % W);
    ones = '1;
    case (op)
      0: return b;
      1: return a + b;
      2: return a - b;
      3: return a * b;
      4: return b == 0 ? a : a / b;
      5: return b == 0 ? a : a % b;
      6: return a & b;
      7: return a | b;
      8: return a ^ b;
      9, 11: return a << sh;
      10: return a >> sh;
      12: return (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0);
      default: return a;
    endcase
  endfunction
  task automatic wait_done(output int lat, input logic hold, input logic [W-1:0] held);
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (hold) chk("acc_hold", bus.acc, held);
      tick();
      lat++;
    end
  endtask
  task automatic send(input int op, input logic [W-1:0] opd, input logic clr);
    int n;
    int lat;
    logic long_op;
    logic [W-1:0] prev;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op_e'(op);
    bus.cmd_operand = opd;
    bus.err_clr = clr;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.err_clr = 1'b0;
    long_op = (op == 4 || op == 5) && opd != 0;
    m_err = ((op == 4 || op == 5) && opd == 0) || (m_err && !clr);
    prev = m_acc;
    m_acc = ref_op(op, m_acc, opd);
    if (long_op) begin
      chk("busy", bus.busy, 1);
      chk("ready_busy", bus.cmd_ready, 0);
    end
    wait_done(lat, long_op, prev);
    chk("latency", lat, long_op ? W + 2 : 1);
    chk("acc", bus.acc, m_acc);
    chk("err", bus.err_div0, m_err);
    chk("ready_done", bus.cmd_ready, 1);
  endtask
  initial begin
    int lat;
    int seen;
    int r;
    logic [W-1:0] opd;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_LOAD;
    bus.cmd_operand = '0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    m_acc = 10;
    m_err = 1'b0;
    chk("rst_acc", bus.acc, 10);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_div0, 0);
    chk("rst_busy", bus.busy, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_operand = 2;
    tick();
    chk("b2b_add", bus.acc, 12);
    chk("b2b_done1", bus.done, 1);
    bus.cmd_op = OP_SUB;
    tick();
    chk("b2b_sub", bus.acc, 10);
    chk("b2b_done2", bus.done, 1);
    bus.cmd_op = OP_MUL;
    tick();
    chk("b2b_mul", bus.acc, 20);
    chk("b2b_done3", bus.done, 1);
    bus.cmd_valid = 1'b0;
    tick();
    chk("b2b_idle", bus.done, 0);
    m_acc = 20;
    send(0, 100, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_DIV;
    bus.cmd_operand = 7;
    tick();
    bus.cmd_op = OP_MOD;
    bus.cmd_operand = 3;
    wait_done(lat, 1'b1, 100);
    chk("div_lat", lat, W + 2);
    chk("div_q", bus.acc, 14);
    chk("div_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("mod_busy", bus.busy, 1);
    wait_done(lat, 1'b1, 14);
    chk("mod_lat", lat, W + 2);
    chk("mod_r", bus.acc, 2);
    m_acc = 2;
    send(0, 32'h8000_0000, 0);
    send(12, 4, 0);
    chk("ashr", bus.acc, 32'hF800_0000);
    send(10, 4, 0);
    chk("shr", bus.acc, 32'h0F80_0000);
    send(9, 36, 0);
    chk("shl36", bus.acc, 32'hF800_0000);
    send(0, 0, 0);
    send(2, 1, 0);
    chk("wrap", bus.acc, 32'hFFFF_FFFF);
    send(4, 0, 0);
    chk("div0_acc", bus.acc, 32'hFFFF_FFFF);
    chk("div0_err", bus.err_div0, 1);
    repeat (3) tick();
    chk("err_sticky", bus.err_div0, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr", bus.err_div0, 0);
    chk("clr_acc", bus.acc, 32'hFFFF_FFFF);
    send(5, 0, 1);
    chk("set_wins", bus.err_div0, 1);
    send(13, 5, 0);
    chk("nop", bus.acc, 32'hFFFF_FFFF);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_DIV;
    bus.cmd_operand = 3;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_acc", bus.acc, 10);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err", bus.err_div0, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | int'(bus.done);
    end
    chk("no_late_done", seen, 0);
    m_acc = 10;
    m_err = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 3);
      opd = r == 0 ? '0 : r == 1 ? W'($urandom_range(1, 20)) : W'($urandom);
      send($urandom_range(0, 15), opd, $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
